// File: rtl/spi_cmd_regfile.sv
// SPI command decoder and 8 x 12-bit register bank; frame N answers command N-1.
// Optional idle watchdog enabled by defining SPI_REGS_WDOG_EN.
module spi_cmd_regfile #(
  parameter logic [11:0] ID_VALUE    = 12'hA5C,
  parameter int unsigned WDOG_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic [15:0] tx_data,
  output logic        tx_update,
  output logic        busy,
  output logic [1:0]  led_out
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        in_decode;
  logic        in_exec;

  logic [15:0] cmd_q;
  logic        dec_rw;
  logic [2:0]  dec_addr;
  logic [11:0] dec_data;
  logic        dec_err;

  logic [11:0] frame_cnt;
  logic [11:0] err_cnt;
  logic        overrun;
  logic        wdog_flag;
  logic        wdog_fire;
  logic        rd_status;

  logic [11:0] rw_reg [3:7];
  logic [11:0] rd_val;
  logic [15:0] resp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Busy also covers the response cycle so a word arriving then is counted as overrun.
  always_comb begin
    in_decode = (state == DECODE);
    in_exec   = (state == EXEC);
    busy      = (state != IDLE) || tx_update;
    accept    = rx_valid && !busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= '0;
      frame_cnt <= '0;
    end else if (accept) begin
      cmd_q     <= rx_data;
      frame_cnt <= frame_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_rw   <= 1'b0;
      dec_addr <= '0;
      dec_data <= '0;
      dec_err  <= 1'b0;
    end else if (in_decode) begin
      dec_rw   <= cmd_q[15];
      dec_addr <= cmd_q[14:12];
      dec_data <= cmd_q[11:0];
      dec_err  <= cmd_q[15] && (cmd_q[14:12] < 3'd3);
    end
  end

  always_comb begin
    rd_status = in_exec && !dec_rw && (dec_addr == 3'd1);
    case (dec_addr)
      3'd0:    rd_val = ID_VALUE;
      3'd1:    rd_val = {overrun, wdog_flag, frame_cnt[9:0]};
      3'd2:    rd_val = err_cnt;
      default: rd_val = rw_reg[dec_addr];
    endcase
    if (dec_err)     resp = {1'b1, dec_addr, 12'hEEE};
    else if (dec_rw) resp = {1'b0, dec_addr, dec_data};
    else             resp = {1'b0, dec_addr, rd_val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= '0;
      tx_update <= 1'b0;
    end else begin
      tx_update <= in_exec;
      if (in_exec) tx_data <= resp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (in_exec && dec_err && (err_cnt != 12'hFFF)) begin
      err_cnt <= err_cnt + 12'd1;
    end
  end

  // A new overrun in the same cycle as a status read stays set.
  always_ff @(posedge clk) begin
    if (rst)                  overrun <= 1'b0;
    else if (rx_valid && busy) overrun <= 1'b1;
    else if (rd_status)        overrun <= 1'b0;
  end

`ifdef SPI_REGS_WDOG_EN
  logic [31:0] wdog_cnt;

  always_comb wdog_fire = !accept && (wdog_cnt == 32'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                   wdog_cnt <= '0;
    else if (accept || wdog_fire) wdog_cnt <= '0;
    else                       wdog_cnt <= wdog_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)            wdog_flag <= 1'b0;
    else if (wdog_fire) wdog_flag <= 1'b1;
    else if (rd_status) wdog_flag <= 1'b0;
  end
`else
  always_comb begin
    wdog_fire = 1'b0;
    wdog_flag = 1'b0;
  end
`endif

  // An EXEC write takes priority over the watchdog clear for its own register.
  always_ff @(posedge clk) begin
    for (int unsigned i = 3; i <= 7; i++) begin
      if (rst)
        rw_reg[i] <= '0;
      else if (in_exec && dec_rw && !dec_err && (dec_addr == 3'(i)))
        rw_reg[i] <= dec_data;
      else if (wdog_fire)
        rw_reg[i] <= '0;
    end
  end

  assign led_out = rw_reg[3][1:0];

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed bench for spi_cmd_regfile: vector table plus overrun, mid-command reset
// and (with SPI_REGS_WDOG_EN) watchdog sequences.
module tb_spi_cmd_regfile;

`ifdef SPI_REGS_WDOG_EN
  localparam int unsigned WD = 16;
`else
  localparam int unsigned WD = 50_000_000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic [15:0] tx_data;
  logic        tx_update;
  logic        busy;
  logic [1:0]  led_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  spi_cmd_regfile #(.ID_VALUE(12'hA5C), .WDOG_CYCLES(WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .tx_update (tx_update),
    .busy      (busy),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] exp_tx;
    logic [1:0]  exp_led;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Waits up to 8 cycles for tx_update; returns the number of cycles waited (8 = timeout).
  task automatic wait_update(output int lat);
    lat = 8;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (tx_update) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_cmd(input logic [15:0] cmd, input logic [15:0] exp_tx,
                        input logic [1:0] exp_led, input string nm);
    int lat;
    logic [15:0] held;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = cmd;
    @(negedge clk);
    rx_valid = 1'b0;
    chk({nm, "_busy_dec"}, 32'(busy), 32'd1);
    wait_update(lat);
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_tx_data"}, 32'(tx_data), 32'(exp_tx));
    chk({nm, "_busy_resp"}, 32'(busy), 32'd1);
    chk({nm, "_led"}, 32'(led_out), 32'(exp_led));
    held = tx_data;
    @(negedge clk);
    chk({nm, "_pulse_end"}, 32'(tx_update), 32'd0);
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    chk({nm, "_tx_hold"}, 32'(tx_data), 32'(held));
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{16'h0000, 16'h0A5C, 2'b00};
    vecs[1]  = '{16'hB123, 16'h3123, 2'b11};
    vecs[2]  = '{16'h3000, 16'h3123, 2'b11};
    vecs[3]  = '{16'h9555, 16'h9EEE, 2'b11};
    vecs[4]  = '{16'h2000, 16'h2001, 2'b11};
    vecs[5]  = '{16'h1000, 16'h1006, 2'b11};
    vecs[6]  = '{16'hC00A, 16'h400A, 2'b11};
    vecs[7]  = '{16'hBABE, 16'h3ABE, 2'b10};
    vecs[8]  = '{16'h4000, 16'h400A, 2'b10};
    vecs[9]  = '{16'h8FFF, 16'h8EEE, 2'b10};
    vecs[10] = '{16'h2000, 16'h2002, 2'b10};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_tx_update", 32'(tx_update), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);

    for (int i = 0; i < 11; i++)
      do_cmd(vecs[i].cmd, vecs[i].exp_tx, vecs[i].exp_led, $sformatf("vec%0d", i));

    // Back-to-back words: second one lands in DECODE and must be dropped.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 16'h1000;
    @(negedge clk);
    rx_data  = 16'h7FFF;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_update(lat);
    chk("ovr_latency", 32'(lat), 32'd1);
    chk("ovr_status", 32'(tx_data), 32'h180C);
    @(negedge clk);
    do_cmd(16'h1000, 16'h100D, 2'b10, "ovr_cleared");

    // Reset while the write sits in DECODE.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 16'hF777;
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_update) seen++;
      @(negedge clk);
    end
    chk("midrst_no_update", 32'(seen), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_led", 32'(led_out), 32'd0);
    do_cmd(16'h7000, 16'h7000, 2'b00, "midrst_reg7");
    do_cmd(16'h1000, 16'h1002, 2'b00, "midrst_frames");

`ifdef SPI_REGS_WDOG_EN
    do_cmd(16'hC0FF, 16'h40FF, 2'b00, "wdog_wr4");
    repeat (20) @(negedge clk);
    do_cmd(16'h4000, 16'h4000, 2'b00, "wdog_reg4");
    do_cmd(16'h1000, 16'h1405, 2'b00, "wdog_flag");
    do_cmd(16'h1000, 16'h1006, 2'b00, "wdog_flag_clr");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
